// File: rtl/mul4_fitness_pkg.sv
// Shared constants, FSM encoding and helpers for the 2x2 multiplier fitness scorer.
package mul4_fitness_pkg;

    localparam int LANES         = 16;
    localparam int BITS_PER_BEAT = 64;
    localparam int BEATS_W       = 9;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        ACCUM  = S_ACCUM,
        DRAIN  = S_DRAIN,
        REPORT = S_REPORT
    } state_t;

    function automatic logic [6:0] popcount64(input logic [BITS_PER_BEAT-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < BITS_PER_BEAT; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mul4_golden.sv
// Combinational bitsliced reference for a 2-bit x 2-bit unsigned multiply, one lane per bit.
module mul4_golden
    import mul4_fitness_pkg::*;
(
    input  logic [LANES-1:0] a1,
    input  logic [LANES-1:0] a0,
    input  logic [LANES-1:0] b1,
    input  logic [LANES-1:0] b0,
    output logic [LANES-1:0] p3,
    output logic [LANES-1:0] p2,
    output logic [LANES-1:0] p1,
    output logic [LANES-1:0] p0
);

    assign p0 = a0 & b0;
    assign p1 = (a1 & b0) ^ (a0 & b1);
    assign p2 = a1 & b1 & ~(a0 & b0);
    assign p3 = a1 & a0 & b1 & b0;

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores batches of candidate multiplier outputs against the golden product and
// reports the number of matching bits per batch through a valid/ready result port.
module mul4_fitness_scorer
    import mul4_fitness_pkg::*;
#(
    parameter int MAX_BEATS = 256,
    parameter int SCORE_W   = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [LANES-1:0]   a1,
    input  logic [LANES-1:0]   a0,
    input  logic [LANES-1:0]   b1,
    input  logic [LANES-1:0]   b0,
    input  logic [LANES-1:0]   y3,
    input  logic [LANES-1:0]   y2,
    input  logic [LANES-1:0]   y1,
    input  logic [LANES-1:0]   y0,
    output logic               score_valid,
    input  logic               score_ready,
    output logic [SCORE_W-1:0] score,
    output logic [BEATS_W-1:0] beats,
    output logic               perfect,
    output logic               overflow
);

    localparam logic [BEATS_W:0] MAX_B = (BEATS_W+1)'(MAX_BEATS);

    state_t                   state;
    logic [LANES-1:0]         p3, p2, p1, p0;
    logic                     accept;
    logic                     consume;
    logic                     s1_valid;
    logic                     s1_last;
    logic                     s2_last;
    logic [BITS_PER_BEAT-1:0] s1_match;
    logic [6:0]               pop;
    logic [SCORE_W:0]         sum;
    logic [SCORE_W-1:0]       acc;
    logic [BEATS_W-1:0]       beat_cnt;
    logic                     ovf;
    logic                     perf;
    logic                     sv;
    logic [31:0]              target;

    mul4_golden u_golden (
        .a1 (a1),
        .a0 (a0),
        .b1 (b1),
        .b0 (b0),
        .p3 (p3),
        .p2 (p2),
        .p1 (p1),
        .p0 (p0)
    );

    assign in_ready = (state == IDLE) || (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign consume  = sv && score_ready;
    assign pop      = popcount64(s1_match);
    assign sum      = {1'b0, acc} + (SCORE_W+1)'(pop);
    assign target   = {17'd0, beat_cnt, 6'd0};

    // DRAIN ends when the last beat's flag has walked out of stage 2, i.e. two cycles in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= in_last ? DRAIN : ACCUM;
                ACCUM:   if (accept && in_last) state <= DRAIN;
                DRAIN:   if (s2_last) state <= REPORT;
                REPORT:  if (consume) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_match <= '0;
            s2_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept && in_last;
            s2_last  <= s1_valid && s1_last;
            if (accept) begin
                s1_match <= ~({y3, y2, y1, y0} ^ {p3, p2, p1, p0});
            end
        end
    end

    // Result registers stay frozen in REPORT because no beats or pipeline work can arrive there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
            perf     <= 1'b0;
            sv       <= 1'b0;
        end else if (state == REPORT && consume) begin
            acc      <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
            perf     <= 1'b0;
            sv       <= 1'b0;
        end else begin
            if (s1_valid) begin
                acc <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            end
            if (accept) begin
                if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if ({1'b0, beat_cnt} >= MAX_B) begin
                    ovf <= 1'b1;
                end
            end
            if (state == DRAIN && s2_last) begin
                perf <= (32'(acc) == target) && !ovf;
            end
            if (state == REPORT && !sv) begin
                sv <= 1'b1;
            end
        end
    end

    assign score_valid = sv;
    assign score       = acc;
    assign beats       = beat_cnt;
    assign perfect     = perf;
    assign overflow    = ovf;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed scoreboard bench for mul4_fitness_scorer using an independent arithmetic product model.
module tb_mul4_fitness_scorer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [15:0] a1 = '0, a0 = '0, b1 = '0, b0 = '0;
    logic [15:0] y3 = '0, y2 = '0, y1 = '0, y0 = '0;
    logic        score_valid;
    logic        score_ready = 1'b0;
    logic [15:0] score;
    logic [8:0]  beats;
    logic        perfect;
    logic        overflow;

    typedef struct {
        int score;
        int beats;
        int perfect;
        int overflow;
    } result_t;

    result_t expq[$];
    int errors = 0;
    int checks = 0;
    int modelScore = 0;
    int modelBeats = 0;
    int modelOvf = 0;

    mul4_fitness_scorer #(.MAX_BEATS(256), .SCORE_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .a1          (a1),
        .a0          (a0),
        .b1          (b1),
        .b0          (b0),
        .y3          (y3),
        .y2          (y2),
        .y1          (y1),
        .y0          (y0),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .score       (score),
        .beats       (beats),
        .perfect     (perfect),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Product computed by integer multiply per lane, independent of the gate equations.
    function automatic logic [63:0] goldenY(input logic [15:0] ga1, ga0, gb1, gb0);
        logic [15:0] g3, g2, g1, g0;
        logic [3:0]  p;
        for (int i = 0; i < 16; i++) begin
            p = {2'b00, ga1[i], ga0[i]} * {2'b00, gb1[i], gb0[i]};
            g3[i] = p[3];
            g2[i] = p[2];
            g1[i] = p[1];
            g0[i] = p[0];
        end
        return {g3, g2, g1, g0};
    endfunction

    function automatic int countMatches(input logic [15:0] ca1, ca0, cb1, cb0, input logic [63:0] cy);
        logic [63:0] g;
        int n;
        g = goldenY(ca1, ca0, cb1, cb0);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (g[i] == cy[i]) n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ta1, ta0, tb1, tb0, input logic [63:0] ty, input logic tlast);
        result_t r;
        int m;
        @(negedge clk);
        a1 = ta1; a0 = ta0; b1 = tb1; b0 = tb0;
        {y3, y2, y1, y0} = ty;
        in_last  = tlast;
        in_valid = 1'b1;
        checkOutput("in_ready_beat", 32'(in_ready), 1);
        m = countMatches(ta1, ta0, tb1, tb0, ty);
        if (modelBeats >= 256) modelOvf = 1;
        modelScore = modelScore + m;
        if (modelScore > 65535) modelScore = 65535;
        if (modelBeats < 511) modelBeats++;
        if (tlast) begin
            r.score    = modelScore;
            r.beats    = modelBeats;
            r.perfect  = ((modelScore == 64 * modelBeats) && (modelOvf == 0)) ? 1 : 0;
            r.overflow = modelOvf;
            expq.push_back(r);
            modelScore = 0;
            modelBeats = 0;
            modelOvf   = 0;
        end
        @(posedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic randomBeat(input logic tlast, input logic correct);
        logic [15:0] ra1, ra0, rb1, rb0;
        logic [63:0] ry;
        ra1 = 16'($urandom); ra0 = 16'($urandom);
        rb1 = 16'($urandom); rb0 = 16'($urandom);
        ry  = correct ? goldenY(ra1, ra0, rb1, rb0) : {$urandom, $urandom};
        applyStimulus(ra1, ra0, rb1, rb0, ry, tlast);
    endtask

    // Called right after the last beat's transfer edge; checks latency, contents, hold and release.
    task automatic checkResult(input int hold);
        result_t e;
        int lat;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (score_valid !== 1'b1 && lat < 20) begin
            checkOutput("in_ready_drain", 32'(in_ready), 0);
            @(negedge clk);
            lat++;
        end
        checkOutput("valid_latency", lat, 3);
        e = expq.pop_front();
        checkOutput("score", 32'(score), e.score);
        checkOutput("beats", 32'(beats), e.beats);
        checkOutput("perfect", 32'(perfect), e.perfect);
        checkOutput("overflow", 32'(overflow), e.overflow);
        checkOutput("in_ready_report", 32'(in_ready), 0);
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b1;
            checkOutput("hold_valid", 32'(score_valid), 1);
            checkOutput("hold_score", 32'(score), e.score);
            checkOutput("hold_beats", 32'(beats), e.beats);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        in_valid    = 1'b0;
        score_ready = 1'b1;
        @(negedge clk);
        score_ready = 1'b0;
        checkOutput("consumed_valid", 32'(score_valid), 0);
        checkOutput("consumed_in_ready", 32'(in_ready), 1);
        checkOutput("cleared_score", 32'(score), 0);
        checkOutput("cleared_beats", 32'(beats), 0);
    endtask

    initial begin
        logic [15:0] ones;
        ones = 16'hFFFF;

        @(negedge clk);
        checkOutput("rst_valid", 32'(score_valid), 0);
        checkOutput("rst_score", 32'(score), 0);
        checkOutput("rst_beats", 32'(beats), 0);
        checkOutput("rst_perfect", 32'(perfect), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 1);

        $display("[TB] single perfect beat");
        applyStimulus(ones, ones, ones, ones, {ones, 16'h0, 16'h0, ones}, 1'b1);
        checkResult(0);

        $display("[TB] single beat, all-zero candidate");
        applyStimulus(ones, ones, ones, ones, 64'h0, 1'b1);
        checkResult(0);

        $display("[TB] four correct beats with gaps");
        randomBeat(1'b0, 1'b1);
        idleCycles(1);
        randomBeat(1'b0, 1'b1);
        randomBeat(1'b0, 1'b1);
        idleCycles(2);
        randomBeat(1'b1, 1'b1);
        checkResult(2);

        $display("[TB] partial matches, result held 10 cycles");
        randomBeat(1'b0, 1'b0);
        randomBeat(1'b0, 1'b0);
        randomBeat(1'b1, 1'b0);
        checkResult(10);

        $display("[TB] 257-beat batch");
        for (int i = 0; i < 257; i++) begin
            randomBeat(i == 256, 1'b1);
        end
        checkResult(0);

        $display("[TB] reset mid-batch");
        randomBeat(1'b0, 1'b0);
        randomBeat(1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midrst_score", 32'(score), 0);
        checkOutput("midrst_beats", 32'(beats), 0);
        modelScore = 0;
        modelBeats = 0;
        modelOvf   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", 32'(score_valid), 0);
            checkOutput("midrst_in_ready", 32'(in_ready), 1);
        end
        randomBeat(1'b1, 1'b0);
        checkResult(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul4_fitness_scorer.md
MUL4_FITNESS_SCORER -- requirements
Module: mul4_fitness_scorer

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 256, meaning the maximum number of beats per batch; a later beat sets overflow.
REQ-002 SHALL have parameter SCORE_W, default 16, meaning the width of the score output.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  beat present.
REQ-007 in_ready  output  1  scorer accepts a beat.
REQ-008 in_last  input  1  final beat of the batch.
REQ-009 a1, a0, b1, b0  input  16 each  bitsliced 2-bit operands; lane i is bit i.
REQ-010 y3, y2, y1, y0  input  16 each  candidate multiplier outputs for the same beat.
REQ-011 score_valid  output  1  result held.
REQ-012 score_ready  input  1  result consumed.
REQ-013 score  output  SCORE_W  count of matching output bits in the batch.
REQ-014 beats  output  9  beats accepted in the batch.
REQ-015 perfect  output  1  every output bit matched.
REQ-016 overflow  output  1  batch exceeded MAX_BEATS.

Function
REQ-017 Golden product per lane: p0=a0&b0; p1=(a1&b0)^(a0&b1); p2=a1&b1&~(a0&b0); p3=a1&a0&b1&b0.
REQ-018 Beat transfer occurs when in_valid&&in_ready; the beat's match count = popcount of ~({y3,y2,y1,y0}^{p3,p2,p1,p0}), range 0..64.
REQ-019 Pipeline: stage 1 registers the 64-bit match vector and the last flag; stage 2 adds the popcount to the accumulator.
REQ-020 FSM states: IDLE, ACCUM, DRAIN, REPORT.
REQ-021 IDLE->ACCUM on the first accepted beat; a beat that is both first and last goes to DRAIN.
REQ-022 ACCUM->DRAIN on an accepted beat with in_last=1.
REQ-023 DRAIN lasts exactly 2 cycles, then REPORT.
REQ-024 REPORT->IDLE on score_ready=1.
REQ-025 in_ready=1 only in IDLE and ACCUM; it is 0 in DRAIN and REPORT.
REQ-026 score_valid asserts 3 cycles after the last beat's transfer edge.
REQ-027 score_valid stays high with score, beats, perfect and overflow stable until score_ready.
REQ-028 score_valid&&score_ready in the same cycle clears score_valid next cycle, and in_ready is 1 that cycle.
REQ-029 The accumulator saturates at 2^SCORE_W-1 and never wraps.
REQ-030 beats saturates at 511.
REQ-031 overflow sets when beats would exceed MAX_BEATS and stays sticky until the result is consumed.
REQ-032 perfect=1 iff score == 64*beats and overflow=0.
REQ-033 When the FSM enters IDLE from REPORT, it clears the accumulator, beats, perfect and overflow.
REQ-034 Gaps in in_valid during ACCUM are legal and add nothing to the score.

Reset
REQ-035 rst_n low SHALL force IDLE, with in_ready=1 after release.
REQ-036 rst_n low SHALL force score_valid=0, score=0, beats=0, perfect=0 and overflow=0.
REQ-037 rst_n low SHALL clear the pipeline valids.
REQ-038 A reset mid-batch or mid-REPORT SHALL discard the batch with no partial result emitted.

Structure
REQ-039 Package mul4_fitness_pkg SHALL hold: LANES=16, BITS_PER_BEAT=64, the state enum type, and the beats width constant 9.
REQ-040 Sub-module mul4_golden SHALL be the combinational bitsliced reference product (REQ-017), instantiated once.

Verification
REQ-041 1 beat, a1=a0=b1=b0=16'hFFFF, y3=y0=16'hFFFF, y2=y1=0, in_last=1 -> score=64, beats=1, perfect=1, valid after 3 cycles.
REQ-042 Same operands with y3..y0=0 -> score=32 (p1 and p2 lanes match), perfect=0.
REQ-043 4 beats with 2 idle gaps, all correct -> score=256, beats=4; in_ready=0 from last beat until score consumed.
REQ-044 score_ready held low 10 cycles -> outputs stable and no beat accepted; score_ready=1 -> in_ready=1 next cycle.
REQ-045 257 beats with MAX_BEATS=256 -> overflow=1, perfect=0, beats=257.
REQ-046 rst_n pulsed low after 2 of 3 beats -> no score_valid; a new 1-beat batch reports only its own score.
